// File: rtl/sd_pkt_replay.sv
// Egress controller for a read-commit FIFO: streams one packet, waits for ack/nack,
// then commits the read pointer or rewinds it so the packet is replayed.
module sd_pkt_replay #(
    parameter int width       = 8,
    parameter int max_retry   = 3,
    parameter int ack_timeout = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             f_srdy,
    output logic                             f_drdy,
    input  logic [width:0]                   f_data,
    output logic                             f_commit,
    output logic                             f_abort,
    output logic                             p_srdy,
    input  logic                             p_drdy,
    output logic [width-1:0]                 p_data,
    output logic                             p_eop,
    input  logic                             ack_srdy,
    output logic                             ack_drdy,
    input  logic                             ack_nack,
    output logic [$clog2(max_retry+1)-1:0]   retry_cnt,
    output logic                             drop
);

    localparam int RW = $clog2(max_retry + 1);
    localparam int TW = (ack_timeout > 1) ? $clog2(ack_timeout) : 1;

    localparam logic [1:0] SEND     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] COMMIT   = 2'd2;
    localparam logic [1:0] ABORT    = 2'd3;

    localparam logic [RW-1:0] RETRY_MAX = RW'(max_retry);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ack_timeout - 1);

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          f_commit_q, f_commit_d;
    logic          f_abort_q, f_abort_d;
    logic          drop_q, drop_d;
    logic          in_send;
    logic          in_wait;
    logic          xfer;
    logic          fail;

    always_comb begin
        in_send  = (state_q == SEND);
        in_wait  = (state_q == WAIT_ACK);
        p_srdy   = in_send & f_srdy;
        f_drdy   = in_send & p_drdy;
        p_data   = f_data[width-1:0];
        p_eop    = f_data[width];
        ack_drdy = in_wait;
        xfer     = in_send & f_srdy & p_drdy;
        // An ack arriving on the last timeout cycle still wins over the timeout.
        fail     = in_wait & ((ack_srdy & ack_nack) | (~ack_srdy & (tmo_q == TMO_LAST)));

        state_d    = state_q;
        retry_d    = retry_q;
        tmo_d      = '0;
        f_commit_d = 1'b0;
        f_abort_d  = 1'b0;
        drop_d     = 1'b0;

        case (state_q)
            SEND: begin
                if (xfer & f_data[width]) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                tmo_d = tmo_q + TW'(1);
                if (ack_srdy & ~ack_nack) begin
                    state_d    = COMMIT;
                    retry_d    = '0;
                    f_commit_d = 1'b1;
                end else if (fail) begin
                    if (retry_q < RETRY_MAX) begin
                        state_d   = ABORT;
                        retry_d   = retry_q + RW'(1);
                        f_abort_d = 1'b1;
                    end else begin
                        // Retries exhausted: release the packet and flag it as dropped.
                        state_d    = COMMIT;
                        retry_d    = '0;
                        f_commit_d = 1'b1;
                        drop_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEND;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SEND;
            retry_q    <= '0;
            tmo_q      <= '0;
            f_commit_q <= 1'b0;
            f_abort_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            f_commit_q <= f_commit_d;
            f_abort_q  <= f_abort_d;
            drop_q     <= drop_d;
        end
    end

    assign f_commit  = f_commit_q;
    assign f_abort   = f_abort_q;
    assign drop      = drop_q;
    assign retry_cnt = retry_q;

endmodule
